// File: rtl/desplazamiento_pkg.sv
// Shared types and defaults for the note-scroll block: FSM states,
// default parameters and the modular pixel-step helper.
package desplazamiento_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    MOVIENDO = 2'd1,
    FIN      = 2'd2
  } estado_t;

  localparam int PASO_PIXELES_DEF   = 4;
  localparam int TICKS_POR_NOTA_DEF = 8;
  localparam int ANCHO_PANTALLA_DEF = 640;
  localparam int PROFUNDIDAD_DEF    = 4;

  // One step of the offset, modulo ancho. ancho is a multiple of
  // paso, so a wrap always lands exactly on 0 or ancho-paso.
  function automatic logic [9:0] mover(
    input logic [9:0]  pos,
    input logic        der,
    input logic [9:0]  paso,
    input logic [10:0] ancho
  );
    logic [10:0] suma;
    suma = {1'b0, pos} + {1'b0, paso};
    if (der)
      mover = (suma >= ancho) ? 10'd0 : suma[9:0];
    else if (pos < paso)
      mover = 10'(ancho - {1'b0, paso});
    else
      mover = pos - paso;
  endfunction

endpackage

// File: rtl/fifo_direcciones.sv
// 1-bit direction request FIFO, PROFUNDIDAD deep.
// Ports: clock/reset, push_i+dato_i, pop_i, dato_o, lleno_o, vacio_o, cuenta_o.
module fifo_direcciones #(
  parameter int PROFUNDIDAD = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push_i,
  input  logic       dato_i,
  input  logic       pop_i,
  output logic       dato_o,
  output logic       lleno_o,
  output logic       vacio_o,
  output logic [2:0] cuenta_o
);

  localparam int AW = (PROFUNDIDAD > 1) ? $clog2(PROFUNDIDAD) : 1;

  logic [PROFUNDIDAD-1:0] mem_q;
  logic [AW-1:0]          wr_q;
  logic [AW-1:0]          rd_q;
  logic [2:0]             cuenta_q;
  logic                   wr_en;
  logic                   rd_en;

  function automatic logic [AW-1:0] sig(input logic [AW-1:0] p);
    sig = (p == AW'(PROFUNDIDAD-1)) ? '0 : p + 1'b1;
  endfunction

  // Fullness is judged on the current count, so a push while full
  // is dropped even if a pop happens in the same cycle.
  assign lleno_o  = (cuenta_q == 3'(PROFUNDIDAD));
  assign vacio_o  = (cuenta_q == 3'd0);
  assign wr_en    = push_i && !lleno_o;
  assign rd_en    = pop_i && !vacio_o;
  assign dato_o   = mem_q[rd_q];
  assign cuenta_o = cuenta_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cuenta_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= dato_i;
        wr_q        <= sig(wr_q);
      end
      if (rd_en)
        rd_q <= sig(rd_q);
      cuenta_q <= cuenta_q + 3'(wr_en) - 3'(rd_en);
    end
  end

endmodule

// File: rtl/desplazamiento_notas.sv
// Animated horizontal note scroll: queued left/right requests, each
// moving 32 px over TICKS_POR_NOTA ticks. Ports: clock, reset,
// movimientoIzquierda/Derecha, tick -> desplazamiento, ocupado,
// pasoCompleto, desbordamiento, pendientes.
module desplazamiento_notas
  import desplazamiento_pkg::*;
#(
  parameter int PASO_PIXELES   = PASO_PIXELES_DEF,
  parameter int TICKS_POR_NOTA = TICKS_POR_NOTA_DEF,
  parameter int ANCHO_PANTALLA = ANCHO_PANTALLA_DEF,
  parameter int PROFUNDIDAD    = PROFUNDIDAD_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       movimientoIzquierda,
  input  logic       movimientoDerecha,
  input  logic       tick,
  output logic [9:0] desplazamiento,
  output logic       ocupado,
  output logic       pasoCompleto,
  output logic       desbordamiento,
  output logic [2:0] pendientes
);

  localparam int CW = $clog2(TICKS_POR_NOTA + 1);

  estado_t       estado_q;
  logic [CW-1:0] cnt_q;
  logic          dir_q;
  logic [9:0]    desp_q;
  logic          ocupado_q;
  logic          paso_q;
  logic          desb_q;

  logic push;
  logic pop;
  logic dato;
  logic lleno;
  logic vacio;

  // Both buttons at once cancel out; the pushed bit is 1 for right.
  assign push = movimientoIzquierda ^ movimientoDerecha;
  assign pop  = (estado_q == REPOSO) && !vacio;

  fifo_direcciones #(
    .PROFUNDIDAD(PROFUNDIDAD)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .dato_i  (movimientoDerecha),
    .pop_i   (pop),
    .dato_o  (dato),
    .lleno_o (lleno),
    .vacio_o (vacio),
    .cuenta_o(pendientes)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= REPOSO;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      desp_q    <= '0;
      ocupado_q <= 1'b0;
      paso_q    <= 1'b0;
      desb_q    <= 1'b0;
    end else begin
      desb_q <= push && lleno;
      unique case (estado_q)
        REPOSO: begin
          if (!vacio) begin
            dir_q     <= dato;
            cnt_q     <= '0;
            ocupado_q <= 1'b1;
            estado_q  <= MOVIENDO;
          end
        end
        MOVIENDO: begin
          if (tick) begin
            desp_q <= mover(desp_q, dir_q,
                            10'(PASO_PIXELES),
                            11'(ANCHO_PANTALLA));
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CW'(TICKS_POR_NOTA-1)) begin
              estado_q <= FIN;
              paso_q   <= 1'b1;
            end
          end
        end
        FIN: begin
          paso_q    <= 1'b0;
          ocupado_q <= 1'b0;
          estado_q  <= REPOSO;
        end
        default: estado_q <= REPOSO;
      endcase
    end
  end

  assign desplazamiento = desp_q;
  assign ocupado        = ocupado_q;
  assign pasoCompleto   = paso_q;
  assign desbordamiento = desb_q;

endmodule

// File: doc/desplazamiento_notas.md
DESPLAZAMIENTO_NOTAS -- requirements
Module: desplazamiento_notas

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clock and reset.
REQ-002 Parameter PASO_PIXELES, default 4, SHALL set the pixels moved per accepted tick.
REQ-003 Parameter TICKS_POR_NOTA, default 8, SHALL set the ticks per note step (32 px per note).
REQ-004 Parameter ANCHO_PANTALLA, default 640, SHALL set the offset modulus and SHALL be a multiple of PASO_PIXELES.
REQ-005 Parameter PROFUNDIDAD, default 4, SHALL set the request FIFO depth.
REQ-006 clock  input  1  system clock, rising edge.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 movimientoIzquierda  input  1  one-cycle request for a one-note left step.
REQ-009 movimientoDerecha  input  1  one-cycle request for a one-note right step.
REQ-010 tick  input  1  one-cycle frame/animation strobe.
REQ-011 desplazamiento  output  10  current horizontal pixel offset, 0..ANCHO_PANTALLA-1.
REQ-012 ocupado  output  1  high while a step is animating (state MOVIENDO or FIN).
REQ-013 pasoCompleto  output  1  one-cycle pulse when a note step finishes.
REQ-014 desbordamiento  output  1  one-cycle pulse when a request is dropped.
REQ-015 pendientes  output  3  FIFO occupancy, 0..PROFUNDIDAD.

Function
REQ-016 A cycle with movimientoIzquierda=1 and movimientoDerecha=0 SHALL push direction 0; the opposite case SHALL push direction 1.
REQ-017 Both request inputs high in one cycle SHALL push nothing and SHALL NOT assert desbordamiento.
REQ-018 Fullness SHALL be evaluated before any same-cycle pop; a push while full SHALL be dropped, with desbordamiento asserted the following cycle for exactly one cycle.
REQ-019 A simultaneous push and pop with the FIFO not full SHALL leave pendientes unchanged.
REQ-020 FSM states SHALL be REPOSO, MOVIENDO and FIN.
REQ-021 REPOSO with pendientes>0 SHALL pop one direction, clear the tick counter and enter MOVIENDO at the next edge (request to ocupado=1: 2 cycles).
REQ-022 In MOVIENDO, each tick SHALL subtract (left) or add (right) PASO_PIXELES to desplazamiento modulo ANCHO_PANTALLA and increment the tick counter.
REQ-023 Wrap-around: left from 0 SHALL give 636; right from 636 SHALL give 0 (default parameters).
REQ-024 The tick that completes TICKS_POR_NOTA moves SHALL transition MOVIENDO to FIN.
REQ-025 FIN SHALL assert pasoCompleto for one cycle and SHALL return to REPOSO unconditionally.
REQ-026 A tick outside MOVIENDO SHALL have no effect.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 On reset: desplazamiento=0, ocupado=0, pasoCompleto=0, desbordamiento=0, pendientes=0, state REPOSO, tick counter 0.
REQ-029 Reset asserted mid-step SHALL abandon the step and discard all queued requests, without waiting for a clock edge.

Structure
REQ-030 Package desplazamiento_pkg SHALL hold the state encoding and the default parameter constants.
REQ-031 The FIFO SHALL be a sub-module fifo_direcciones (1-bit wide, PROFUNDIDAD deep, push/pop/full/empty/count).

Verification
REQ-032 One left pulse, tick every 4 cycles: desplazamiento 636, 632 ... 608 after 8 ticks; a single pasoCompleto pulse; ocupado low afterwards.
REQ-033 Start at 636, one right pulse: desplazamiento 0, 4 ... 28; no glitch at the wrap.
REQ-034 Six left pulses on consecutive cycles while idle: 5 accepted, one desbordamiento pulse, final desplazamiento 480.
REQ-035 Both request inputs high for one cycle: pendientes stays 0, ocupado stays 0, no desbordamiento.
REQ-036 Reset asserted after 3 ticks of a step: all outputs 0 immediately (asynchronously); no pasoCompleto after release.
REQ-037 10 ticks in REPOSO with no requests: desplazamiento unchanged.
